writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 16 +
 rtl/wb_aux_fifo.sv | 104 ++++++++++
 rtl/writeback_arbiter.sv | 124 ++++++++++++
 tb/tb_writeback_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types and constants.
// Register address width, data width, zero register, aux FIFO states.
package writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/wb_aux_fifo.sv
// Two-entry in-order FIFO for mul/div results awaiting writeback.
// Ports: push/pop strobes, head entry, empty/full flags, dest-reg hazard query.
module wb_aux_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_reg_i,
  input  logic [DW-1:0]         push_data_i,
  input  logic                  pop_i,
  input  logic [REG_ADDR_W-1:0] query_reg_i,
  output logic                  query_hit_o,
  output logic [REG_ADDR_W-1:0] head_reg_o,
  output logic [DW-1:0]         head_data_o,
  output logic                  not_empty_o,
  output logic                  full_o
);

  fifo_state_e state_q, state_d;
  logic wr_ptr_q, wr_ptr_d;
  logic rd_ptr_q, rd_ptr_d;
  logic [REG_ADDR_W-1:0] reg_q [2];
  logic [REG_ADDR_W-1:0] reg_d [2];
  logic [DW-1:0] data_q [2];
  logic [DW-1:0] data_d [2];

  logic push_ok;
  logic pop_ok;
  logic [1:0] vld;
  logic [1:0] hit;

  assign not_empty_o = (state_q != EMPTY);
  assign full_o      = (state_q == FULL);

  // Never overfill or underflow, whatever the caller asks.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && not_empty_o;

  assign head_reg_o  = reg_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // Hazard view uses pre-update contents.
  always_comb begin
    vld = 2'b00;
    hit = 2'b00;
    for (int i = 0; i < 2; i++) begin
      vld[i] = full_o ||
               ((state_q == ONE) && (rd_ptr_q == 1'(i)));
      hit[i] = vld[i] && (reg_q[i] == query_reg_i);
    end
    query_hit_o = (query_reg_i != ZERO_REG) && (|hit);
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    reg_d    = reg_q;
    data_d   = data_q;
    if (push_ok) begin
      reg_d[wr_ptr_q]  = push_reg_i;
      data_d[wr_ptr_q] = push_data_i;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case (state_q)
      EMPTY: begin
        if (push_ok) state_d = ONE;
      end
      ONE: begin
        if (push_ok && !pop_ok) state_d = FULL;
        else if (pop_ok && !push_ok) state_d = EMPTY;
      end
      FULL: begin
        if (pop_ok) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        reg_q[i]  <= ZERO_REG;
        data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges MEM/WB writes with queued mul/div results onto one RF port.
// Ports: pipe slot in, aux valid/ready in, hazard query, stall, RF write out.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Pipe_valid,
  input  logic                  Pipe_RegWrite,
  input  logic                  Pipe_MemtoReg,
  input  logic [DATA_WIDTH-1:0] Pipe_ALU_result,
  input  logic [DATA_WIDTH-1:0] Pipe_Mem_data,
  input  logic [REG_ADDR_W-1:0] Pipe_Write_register,
  input  logic                  Aux_valid,
  output logic                  Aux_ready,
  input  logic [REG_ADDR_W-1:0] Aux_Write_register,
  input  logic [DATA_WIDTH-1:0] Aux_Write_data,
  input  logic [REG_ADDR_W-1:0] Query_register,
  output logic                  Query_pending,
  output logic                  Stall_request,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] Write_register,
  output logic [DATA_WIDTH-1:0] Write_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic pipe_cand;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_ne;
  logic fifo_full;
  logic [REG_ADDR_W-1:0] head_reg;
  logic [DATA_WIDTH-1:0] head_data;

  logic we_q, we_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0] starve_q, starve_d;
  logic stall_q, stall_d;

  assign pipe_cand = Pipe_valid && Pipe_RegWrite &&
                     (Pipe_Write_register != ZERO_REG);
  assign pipe_data = Pipe_MemtoReg ? Pipe_Mem_data
                                   : Pipe_ALU_result;

  assign Aux_ready = !fifo_full;
  // r0 pushes are handshaken but dropped here.
  assign fifo_push = Aux_valid && Aux_ready &&
                     (Aux_Write_register != ZERO_REG);
  // Pipe always wins; aux drains only in pipe-idle cycles.
  assign fifo_pop  = fifo_ne && !pipe_cand;

  wb_aux_fifo #(
    .DW(DATA_WIDTH)
  ) u_fifo (
    .clk         (Clock),
    .rst_n       (Reset_n),
    .push_i      (fifo_push),
    .push_reg_i  (Aux_Write_register),
    .push_data_i (Aux_Write_data),
    .pop_i       (fifo_pop),
    .query_reg_i (Query_register),
    .query_hit_o (Query_pending),
    .head_reg_o  (head_reg),
    .head_data_o (head_data),
    .not_empty_o (fifo_ne),
    .full_o      (fifo_full)
  );

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      pipe_cand: begin
        we_d    = 1'b1;
        wreg_d  = Pipe_Write_register;
        wdata_d = pipe_data;
      end
      fifo_pop: begin
        we_d    = 1'b1;
        wreg_d  = head_reg;
        wdata_d = head_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!fifo_ne || fifo_pop) starve_d = '0;
    else if (starve_q != LIM) starve_d = starve_q + CW'(1);
    // Raised once the counter has sat at the limit; drops with the pop.
    stall_d = fifo_ne && !fifo_pop && (starve_q == LIM);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      we_q     <= 1'b0;
      wreg_q   <= ZERO_REG;
      wdata_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign RegWrite       = we_q;
  assign Write_register = wreg_q;
  assign Write_data     = wdata_q;
  assign Stall_request  = stall_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed-vector bench for writeback_arbiter.
// Drives pipe/aux traffic and checks the registered RF port and flags.
module tb_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p_valid;
  logic        p_rw;
  logic        p_m2r;
  logic [31:0] p_alu;
  logic [31:0] p_mem;
  logic [4:0]  p_reg;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic [4:0]  q_reg;
  logic        q_pend;
  logic        stall;
  logic        rw;
  logic [4:0]  wreg;
  logic [31:0] wdata;

  int n_vec;
  int n_err;

  writeback_arbiter #(
    .STARVE_LIMIT(4),
    .DATA_WIDTH  (32)
  ) dut (
    .Clock               (clk),
    .Reset_n             (rst_n),
    .Pipe_valid          (p_valid),
    .Pipe_RegWrite       (p_rw),
    .Pipe_MemtoReg       (p_m2r),
    .Pipe_ALU_result     (p_alu),
    .Pipe_Mem_data       (p_mem),
    .Pipe_Write_register (p_reg),
    .Aux_valid           (a_valid),
    .Aux_ready           (a_ready),
    .Aux_Write_register  (a_reg),
    .Aux_Write_data      (a_data),
    .Query_register      (q_reg),
    .Query_pending       (q_pend),
    .Stall_request       (stall),
    .RegWrite            (rw),
    .Write_register      (wreg),
    .Write_data          (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic m2r,
                      input logic [31:0] alu,
                      input logic [31:0] mem,
                      input logic [4:0] r);
    p_valid = v;
    p_rw    = v;
    p_m2r   = m2r;
    p_alu   = alu;
    p_mem   = mem;
    p_reg   = r;
  endtask

  task automatic aux(input logic v, input logic [4:0] r,
                     input logic [31:0] d);
    a_valid = v;
    a_reg   = r;
    a_data  = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    pipe(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    aux(1'b0, 5'd0, 32'd0);
    q_reg = 5'd0;

    #3;
    chk("rst_we", 32'(rw), 32'd0);
    chk("rst_reg", 32'(wreg), 32'd0);
    chk("rst_data", wdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_we", 32'(rw), 32'd0);

    // Pipe-only, ALU then memory data.
    pipe(1'b1, 1'b0, 32'd100, 32'd200, 5'd1);
    step();
    chk("alu_we", 32'(rw), 32'd1);
    chk("alu_reg", 32'(wreg), 32'd1);
    chk("alu_data", wdata, 32'd100);
    pipe(1'b1, 1'b1, 32'd100, 32'd200, 5'd1);
    step();
    chk("mem_data", wdata, 32'd200);
    pipe(1'b0, 1'b0, 32'd7, 32'd8, 5'd9);
    step();
    chk("idle_we", 32'(rw), 32'd0);
    chk("idle_hold_reg", 32'(wreg), 32'd1);
    chk("idle_hold_data", wdata, 32'd200);

    // Zero-register filtering.
    pipe(1'b1, 1'b0, 32'd55, 32'd0, 5'd0);
    step();
    chk("r0_pipe_we", 32'(rw), 32'd0);
    chk("r0_pipe_data", wdata, 32'd200);
    pipe(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    aux(1'b1, 5'd0, 32'd77);
    step();
    aux(1'b0, 5'd0, 32'd0);
    chk("r0_aux_ready", 32'(a_ready), 32'd1);
    step();
    chk("r0_aux_we", 32'(rw), 32'd0);

    // Conflict: pipe holds port for 3 cycles.
    q_reg = 5'd3;
    pipe(1'b1, 1'b0, 32'd200, 32'd0, 5'd2);
    aux(1'b1, 5'd3, 32'd300);
    chk("cf_qp_prepush", 32'(q_pend), 32'd0);
    step();
    aux(1'b0, 5'd0, 32'd0);
    chk("cf_e0_reg", 32'(wreg), 32'd2);
    chk("cf_e0_qp", 32'(q_pend), 32'd1);
    step();
    chk("cf_e1_reg", 32'(wreg), 32'd2);
    chk("cf_e1_qp", 32'(q_pend), 32'd1);
    step();
    chk("cf_e2_reg", 32'(wreg), 32'd2);
    chk("cf_e2_data", wdata, 32'd200);
    pipe(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    chk("cf_qp_prepop", 32'(q_pend), 32'd1);
    step();
    chk("cf_aux_we", 32'(rw), 32'd1);
    chk("cf_aux_reg", 32'(wreg), 32'd3);
    chk("cf_aux_data", wdata, 32'd300);
    chk("cf_qp_after", 32'(q_pend), 32'd0);

    // Full and starvation.
    q_reg = 5'd5;
    pipe(1'b1, 1'b0, 32'd200, 32'd0, 5'd2);
    aux(1'b1, 5'd4, 32'd400);
    step();
    chk("fs_ready1", 32'(a_ready), 32'd1);
    aux(1'b1, 5'd5, 32'd500);
    step();
    aux(1'b0, 5'd0, 32'd0);
    chk("fs_full_ready", 32'(a_ready), 32'd0);
    chk("fs_qp5", 32'(q_pend), 32'd1);
    chk("fs_stall_e1", 32'(stall), 32'd0);
    step();
    step();
    step();
    chk("fs_stall_e4", 32'(stall), 32'd0);
    step();
    chk("fs_stall_e5", 32'(stall), 32'd1);
    chk("fs_pipe_reg", 32'(wreg), 32'd2);
    pipe(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    step();
    chk("fs_pop1_reg", 32'(wreg), 32'd4);
    chk("fs_pop1_data", wdata, 32'd400);
    chk("fs_pop1_stall", 32'(stall), 32'd0);
    chk("fs_pop1_ready", 32'(a_ready), 32'd1);
    step();
    chk("fs_pop2_we", 32'(rw), 32'd1);
    chk("fs_pop2_reg", 32'(wreg), 32'd5);
    chk("fs_pop2_data", wdata, 32'd500);
    step();
    chk("fs_drained_we", 32'(rw), 32'd0);

    // Reset with two queued entries.
    q_reg = 5'd6;
    pipe(1'b1, 1'b0, 32'd200, 32'd0, 5'd2);
    aux(1'b1, 5'd6, 32'd600);
    step();
    aux(1'b1, 5'd7, 32'd700);
    step();
    aux(1'b0, 5'd0, 32'd0);
    chk("mr_full_ready", 32'(a_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_we", 32'(rw), 32'd0);
    chk("mr_reg", 32'(wreg), 32'd0);
    chk("mr_data", wdata, 32'd0);
    chk("mr_stall", 32'(stall), 32'd0);
    chk("mr_ready", 32'(a_ready), 32'd1);
    chk("mr_qp", 32'(q_pend), 32'd0);
    pipe(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mr_rel_we1", 32'(rw), 32'd0);
    step();
    chk("mr_rel_we2", 32'(rw), 32'd0);
    chk("mr_rel_ready", 32'(a_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
